ahb3lite_mem_slave_if: RTL and testbench
========================================

Name: ahb3lite_mem_slave_if

Overview:
AHB3-Lite slave protocol front-end that sits directly upstream of the word-addressed memory array. It samples address-phase signals, turns each accepted transfer into a data-phase read or write strobe with a word address, and drives HREADYOUT/HRESP. It inserts optional read wait states and returns a two-cycle ERROR response for unsupported or out-of-range transfers. The memory array itself is combinational-read, synchronous-write, and lies outside this block.

Parameters:
MEM_DEPTH, 4096, number of 32-bit words in the attached memory; legal word index is 0..MEM_DEPTH-1
RD_WAIT, 0, wait states inserted on every read data phase (0..15)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  32  byte address, address phase
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  in  1  1=write
HSIZE  in  3  transfer size; only 3'b010 (word) is legal
HREADY  in  1  bus-level ready (from interconnect mux)
HWDATA  in  32  write data, data phase
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
READ_addr  out  32  word index to memory
read_flag  out  1  memory read enable
WRITE_addr  out  32  word index to memory
write_flag  out  1  memory write enable, committed on the HCLK rising edge
mem_wdata  out  32  write data to memory (equals HWDATA during a write data phase)

Behaviour:
- Clocking: single clock, HCLK. HRESETn is asynchronous and active-low.
- Reset values:
  - HREADYOUT=1, HRESP=0
  - read_flag=0, write_flag=0
  - READ_addr=0, WRITE_addr=0
  - wait counter=0, state=IDLE
- Acceptance: a transfer is accepted at a rising edge when HSEL & HTRANS[1] & HREADY are all 1.
  - IDLE and BUSY transfers, or HSEL=0, get a zero-wait OKAY response.
  - With HREADY=0 the block captures nothing.
- Captured registers: the write bit, the word index HADDR[31:2], and a legal bit. legal = (HSIZE==3'b010) & (HADDR[1:0]==0) & (HADDR[31:2] < MEM_DEPTH).
- States:
  - IDLE: HREADYOUT=1, HRESP=0, both flags 0.
  - WR: one cycle. write_flag=1, WRITE_addr=captured index, mem_wdata=HWDATA, HREADYOUT=1. The memory commits at the edge that ends this cycle, so writes have zero wait states.
  - RD: read_flag=1 and READ_addr=captured index for the whole data phase. HREADYOUT stays 0 for RD_WAIT cycles, counted down by the counter, then goes to 1 for one cycle.
  - ERR1: HREADYOUT=0, HRESP=1, flags 0.
  - ERR2: HREADYOUT=1, HRESP=1, flags 0.
- Transitions:
  - An accepted legal write goes to WR; an accepted legal read goes to RD; an accepted illegal transfer goes to ERR1.
  - ERR1 always goes to ERR2.
  - From WR, ERR2, or the final (ready) cycle of RD, the next state follows the acceptance rule applied in that same cycle, which gives back-to-back pipelining. With no acceptance, the next state is IDLE.
  - No transfer is accepted during an RD wait cycle or ERR1, because HREADY is low.
- Read-after-write to the same address: the read data phase always follows the write commit edge, so it returns the new data. No forwarding logic is required.
- Illegal transfers never assert write_flag, so memory contents are untouched.
- Address width: the index is HADDR[31:2], zero-extended to 32 bits on READ_addr and WRITE_addr.
- Reset asserted mid-transfer: all outputs return to their reset values immediately (asynchronously). A pending write is dropped and a read wait is abandoned.
- Flags are 0 whenever the block is not in WR or RD. Address outputs hold their last value.

Decomposition:
- Shared package ahb3lite_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - HSIZE_WORD
  - HRESP_OKAY/ERROR
  - slave state enum {IDLE, WR, RD, ERR1, ERR2}
- No sub-module is needed; the wait counter and FSM live in one module.

Test Plan:
- Write 0x0000_0040 ← 0xDEADBEEF, then a NONSEQ read of the same address, RD_WAIT=0 → write_flag=1 for one cycle with WRITE_addr=0x10; read data phase has read_flag=1, READ_addr=0x10, HREADYOUT=1, HRDATA=0xDEADBEEF.
- Back-to-back writes to 0x0, 0x4, 0x8 with data 1, 2, 3, then reads of the same addresses → HREADYOUT is never low, data returned 1, 2, 3 in order.
- RD_WAIT=2, read 0x100 → HREADYOUT=0 for 2 cycles, then 1 for one cycle. read_flag=1 for all 3 cycles with READ_addr=0x40.
- Illegal transfers: HSIZE=3'b001 at 0x8; write to byte address 4*MEM_DEPTH; HADDR=0x2 → each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1). write_flag stays 0 and a follow-up read of word 2 shows it unchanged.
- HTRANS=BUSY, then IDLE, then HSEL=0 with NONSEQ → HREADYOUT=1, HRESP=0, no flags asserted.
- RD_WAIT=3, assert HRESETn=0 during the second wait cycle → HREADYOUT=1, HRESP=0, read_flag=0 immediately. After release, a new write is accepted normally.

Source files
------------

// File: rtl/ahb3lite_mem_slave_if_pkg.sv
// Shared AHB3-Lite constants and the slave data-phase state type.
// Imported by the slave front-end and its bus interface.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_ERR1,
        ST_ERR2
    } slv_state_t;

endpackage

// File: rtl/ahb3lite_mem_slave_if_if.sv
// Bus bundle between an AHB3-Lite master/interconnect and the memory
// slave front-end: address/data phase inputs, response and memory strobes.
interface ahb3lite_mem_slave_if_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] READ_addr;
    logic        read_flag;
    logic [31:0] WRITE_addr;
    logic        write_flag;
    logic [31:0] mem_wdata;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HREADYOUT, HRESP,
        output READ_addr, read_flag, WRITE_addr, write_flag, mem_wdata
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HREADYOUT, HRESP,
        input  READ_addr, read_flag, WRITE_addr, write_flag, mem_wdata
    );

endinterface

// File: rtl/ahb3lite_mem_slave_if.sv
// AHB3-Lite slave front-end for a word-addressed memory array.
// Ports: HCLK, HRESETn (async, active-low), bus (slave modport):
//   AHB address/data phase in, HREADYOUT/HRESP out, read/write strobes
//   with word index and write data towards the memory.
module ahb3lite_mem_slave_if #(
    parameter int MEM_DEPTH = 4096,
    parameter int RD_WAIT   = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    ahb3lite_mem_slave_if_if.slave bus
);

    import ahb3lite_pkg::*;

    slv_state_t  r_state;
    logic [3:0]  r_cnt;
    logic        r_hreadyout;
    logic        r_hresp;
    logic        r_read_flag;
    logic        r_write_flag;
    logic [31:0] r_read_addr;
    logic [31:0] r_write_addr;

    logic        w_accept;
    logic        w_legal;
    logic        w_free;
    logic [31:0] w_idx;

    assign w_accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign w_idx    = {2'b00, bus.HADDR[31:2]};
    assign w_legal  = (bus.HSIZE == HSIZE_WORD) &&
                      (bus.HADDR[1:0] == 2'b00) &&
                      (w_idx < 32'(MEM_DEPTH));

    // Cycles in which HREADYOUT is high, so the next address phase may
    // be taken: this is what gives back-to-back pipelining.
    assign w_free = (r_state == ST_IDLE) || (r_state == ST_WR) ||
                    (r_state == ST_ERR2) ||
                    ((r_state == ST_RD) && (r_cnt == 4'd0));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_hreadyout  <= 1'b1;
            r_hresp      <= HRESP_OKAY;
            r_read_flag  <= 1'b0;
            r_write_flag <= 1'b0;
            r_read_addr  <= 32'd0;
            r_write_addr <= 32'd0;
        end else if (w_free) begin
            r_state      <= ST_IDLE;
            r_hreadyout  <= 1'b1;
            r_hresp      <= HRESP_OKAY;
            r_read_flag  <= 1'b0;
            r_write_flag <= 1'b0;
            if (w_accept) begin
                if (!w_legal) begin
                    r_state     <= ST_ERR1;
                    r_hreadyout <= 1'b0;
                    r_hresp     <= HRESP_ERROR;
                end else if (bus.HWRITE) begin
                    r_state      <= ST_WR;
                    r_write_flag <= 1'b1;
                    r_write_addr <= w_idx;
                end else begin
                    r_state     <= ST_RD;
                    r_read_flag <= 1'b1;
                    r_read_addr <= w_idx;
                    r_cnt       <= 4'(RD_WAIT);
                    r_hreadyout <= (RD_WAIT == 0);
                end
            end
        end else begin
            case (r_state)
                ST_RD: begin
                    // Ready rises in the cycle the counter reaches zero.
                    r_cnt       <= r_cnt - 4'd1;
                    r_hreadyout <= (r_cnt == 4'd1);
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_hreadyout  <= 1'b1;
                    r_hresp      <= HRESP_OKAY;
                    r_read_flag  <= 1'b0;
                    r_write_flag <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HREADYOUT  = r_hreadyout;
    assign bus.HRESP      = r_hresp;
    assign bus.read_flag  = r_read_flag;
    assign bus.write_flag = r_write_flag;
    assign bus.READ_addr  = r_read_addr;
    assign bus.WRITE_addr = r_write_addr;
    assign bus.mem_wdata  = bus.HWDATA;

endmodule

// File: tb/tb_ahb3lite_mem_slave_if.sv
// Directed bench for the AHB3-Lite memory slave front-end.
// Three instances (RD_WAIT 0/2/3) share one stimulus stream.
module tb_ahb3lite_mem_slave_if;

    import ahb3lite_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic        s_sel;
    logic [31:0] s_addr;
    logic [1:0]  s_trans;
    logic        s_write;
    logic [2:0]  s_size;
    logic [31:0] s_wdata;
    logic [31:0] w_hrdata;
    logic [31:0] mem [0:4095];

    int n_chk;
    int n_fail;

    ahb3lite_mem_slave_if_if b0 ();
    ahb3lite_mem_slave_if_if b2 ();
    ahb3lite_mem_slave_if_if b3 ();

    assign b0.HSEL = s_sel;   assign b2.HSEL = s_sel;   assign b3.HSEL = s_sel;
    assign b0.HADDR = s_addr; assign b2.HADDR = s_addr; assign b3.HADDR = s_addr;
    assign b0.HTRANS = s_trans; assign b2.HTRANS = s_trans; assign b3.HTRANS = s_trans;
    assign b0.HWRITE = s_write; assign b2.HWRITE = s_write; assign b3.HWRITE = s_write;
    assign b0.HSIZE = s_size; assign b2.HSIZE = s_size; assign b3.HSIZE = s_size;
    assign b0.HWDATA = s_wdata; assign b2.HWDATA = s_wdata; assign b3.HWDATA = s_wdata;
    assign b0.HREADY = b0.HREADYOUT;
    assign b2.HREADY = b2.HREADYOUT;
    assign b3.HREADY = b3.HREADYOUT;

    ahb3lite_mem_slave_if #(.MEM_DEPTH(4096), .RD_WAIT(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(b0.slave)
    );
    ahb3lite_mem_slave_if #(.MEM_DEPTH(4096), .RD_WAIT(2)) u_dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(b2.slave)
    );
    ahb3lite_mem_slave_if #(.MEM_DEPTH(4096), .RD_WAIT(3)) u_dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(b3.slave)
    );

    // Memory array behind instance 0: comb read, sync write.
    always @(posedge HCLK)
        if (b0.write_flag)
            mem[b0.WRITE_addr[11:0]] <= b0.mem_wdata;
    assign w_hrdata = mem[b0.READ_addr[11:0]];

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ap(input logic sel, input logic [1:0] tr,
                      input logic wr, input logic [2:0] sz,
                      input logic [31:0] a);
        s_sel   = sel;
        s_trans = tr;
        s_write = wr;
        s_size  = sz;
        s_addr  = a;
    endtask

    task automatic idle();
        ap(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'd0);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    logic [2:0]  ill_sz [3];
    logic [31:0] ill_ad [3];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        idle();
        s_wdata = 32'd0;
        HRESETn = 1'b0;
        #12;
        chk("rst_hready", {31'd0, b0.HREADYOUT}, 32'd1);
        chk("rst_hresp", {31'd0, b0.HRESP}, 32'd0);
        chk("rst_flags", {30'd0, b0.read_flag, b0.write_flag}, 32'd0);
        chk("rst_raddr", b0.READ_addr, 32'd0);
        chk("rst_waddr", b0.WRITE_addr, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();

        // Write then read 0x40.
        ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40);
        tick();
        s_wdata = 32'hDEADBEEF;
        ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40);
        chk("wr_flag", {31'd0, b0.write_flag}, 32'd1);
        chk("wr_addr", b0.WRITE_addr, 32'h10);
        chk("wr_data", b0.mem_wdata, 32'hDEADBEEF);
        chk("wr_hready", {31'd0, b0.HREADYOUT}, 32'd1);
        tick();
        idle();
        chk("rd_flag", {31'd0, b0.read_flag}, 32'd1);
        chk("rd_wflag", {31'd0, b0.write_flag}, 32'd0);
        chk("rd_addr", b0.READ_addr, 32'h10);
        chk("rd_hready", {31'd0, b0.HREADYOUT}, 32'd1);
        chk("rd_data", w_hrdata, 32'hDEADBEEF);
        tick();
        chk("post_rd_flag", {31'd0, b0.read_flag}, 32'd0);

        // Back-to-back writes 1,2,3 then reads.
        ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0);
        tick();
        s_wdata = 32'd1;
        ap(1'b1, HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'h4);
        chk("b2b_w0_addr", b0.WRITE_addr, 32'd0);
        chk("b2b_w0_rdy", {31'd0, b0.HREADYOUT}, 32'd1);
        tick();
        s_wdata = 32'd2;
        ap(1'b1, HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'h8);
        chk("b2b_w1_addr", b0.WRITE_addr, 32'd1);
        chk("b2b_w1_rdy", {31'd0, b0.HREADYOUT}, 32'd1);
        tick();
        s_wdata = 32'd3;
        ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        chk("b2b_w2_addr", b0.WRITE_addr, 32'd2);
        chk("b2b_w2_flag", {31'd0, b0.write_flag}, 32'd1);
        tick();
        ap(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h4);
        chk("b2b_r0_data", w_hrdata, 32'd1);
        chk("b2b_r0_rdy", {31'd0, b0.HREADYOUT}, 32'd1);
        tick();
        ap(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h8);
        chk("b2b_r1_data", w_hrdata, 32'd2);
        chk("b2b_r1_rdy", {31'd0, b0.HREADYOUT}, 32'd1);
        tick();
        idle();
        chk("b2b_r2_data", w_hrdata, 32'd3);
        chk("b2b_r2_flag", {31'd0, b0.read_flag}, 32'd1);
        tick();

        // Read 0x100 with two wait states (instance 2).
        ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h100);
        tick();
        idle();
        chk("w2_c0_rdy", {31'd0, b2.HREADYOUT}, 32'd0);
        chk("w2_c0_flag", {31'd0, b2.read_flag}, 32'd1);
        chk("w2_c0_addr", b2.READ_addr, 32'h40);
        tick();
        chk("w2_c1_rdy", {31'd0, b2.HREADYOUT}, 32'd0);
        chk("w2_c1_flag", {31'd0, b2.read_flag}, 32'd1);
        tick();
        chk("w2_c2_rdy", {31'd0, b2.HREADYOUT}, 32'd1);
        chk("w2_c2_flag", {31'd0, b2.read_flag}, 32'd1);
        chk("w2_c2_addr", b2.READ_addr, 32'h40);
        tick();
        chk("w2_done_flag", {31'd0, b2.read_flag}, 32'd0);
        chk("w3_last_rdy", {31'd0, b3.HREADYOUT}, 32'd1);
        tick();
        tick();

        // Illegal transfers: bad size, out of range, misaligned.
        ill_sz[0] = 3'b001;     ill_ad[0] = 32'h8;
        ill_sz[1] = HSIZE_WORD; ill_ad[1] = 32'h4000;
        ill_sz[2] = HSIZE_WORD; ill_ad[2] = 32'h2;
        for (int i = 0; i < 3; i++) begin
            ap(1'b1, HTRANS_NONSEQ, 1'b1, ill_sz[i], ill_ad[i]);
            tick();
            s_wdata = 32'hBAD0_0000;
            idle();
            chk($sformatf("ill%0d_e1_rdy", i), {31'd0, b0.HREADYOUT}, 32'd0);
            chk($sformatf("ill%0d_e1_resp", i), {31'd0, b0.HRESP}, 32'd1);
            chk($sformatf("ill%0d_e1_wf", i), {31'd0, b0.write_flag}, 32'd0);
            tick();
            chk($sformatf("ill%0d_e2_rdy", i), {31'd0, b0.HREADYOUT}, 32'd1);
            chk($sformatf("ill%0d_e2_resp", i), {31'd0, b0.HRESP}, 32'd1);
            chk($sformatf("ill%0d_e2_wf", i), {31'd0, b0.write_flag}, 32'd0);
            tick();
            chk($sformatf("ill%0d_end_resp", i), {31'd0, b0.HRESP}, 32'd0);
        end
        ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8);
        tick();
        idle();
        chk("ill_word2", w_hrdata, 32'd3);
        tick();
        tick();
        tick();

        // No-op transfers: BUSY, IDLE, deselected NONSEQ.
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: ap(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h20);
                1: ap(1'b1, HTRANS_IDLE, 1'b1, HSIZE_WORD, 32'h20);
                default: ap(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20);
            endcase
            tick();
            chk($sformatf("nop%0d_rdy", i), {31'd0, b0.HREADYOUT}, 32'd1);
            chk($sformatf("nop%0d_resp", i), {31'd0, b0.HRESP}, 32'd0);
            chk($sformatf("nop%0d_flags", i),
                {30'd0, b0.read_flag, b0.write_flag}, 32'd0);
        end
        idle();
        tick();

        // Reset in the second wait cycle of a 3-wait read (instance 3).
        ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        tick();
        idle();
        chk("rst3_c0_rdy", {31'd0, b3.HREADYOUT}, 32'd0);
        tick();
        chk("rst3_c1_rdy", {31'd0, b3.HREADYOUT}, 32'd0);
        chk("rst3_c1_flag", {31'd0, b3.read_flag}, 32'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rst3_rdy", {31'd0, b3.HREADYOUT}, 32'd1);
        chk("rst3_resp", {31'd0, b3.HRESP}, 32'd0);
        chk("rst3_flag", {31'd0, b3.read_flag}, 32'd0);
        tick();
        HRESETn = 1'b1;
        ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'hC);
        tick();
        s_wdata = 32'h55;
        idle();
        chk("rst3_wr_flag", {31'd0, b3.write_flag}, 32'd1);
        chk("rst3_wr_addr", b3.WRITE_addr, 32'd3);
        chk("rst3_wr_rdy", {31'd0, b3.HREADYOUT}, 32'd1);
        tick();
        chk("rst3_wr_end", {31'd0, b3.write_flag}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
